unidade_entrada: RTL

- Producer side of the processor's IN path. Supplies the 14-bit operand DadoLido_Entrada that the output multiplexer widens into the register file.
- On an IN instruction it stalls the datapath and waits for the operator to confirm with a push-button. It then latches the switch value and releases the stall for exactly one cycle so the instruction retires.
- Contains button synchronizer/debouncer, switch synchronizer, and a 4-state FSM.

---
 rtl/unidade_entrada.sv | 115 +++++++++++
 1 files changed

// File: rtl/unidade_entrada.sv
// IN-path producer: stalls on an IN instruction until the operator confirms with a
// debounced push-button, latches the synchronized switches, then releases the stall for one retire cycle.
module unidade_entrada #(
    parameter int DATA_W          = 14,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              In,
    input  logic [DATA_W-1:0] Chaves,
    input  logic              BotaoConfirma,
    output logic [DATA_W-1:0] DadoLido_Entrada,
    output logic              Pausa,
    output logic              EsperandoEntrada,
    output logic              Valido
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESPERA_SOLTAR = 2'd1,
        ESPERA_APERTO = 2'd2,
        CONCLUIDO     = 2'd3
    } estado_t;

    estado_t           state_q, state_d;
    logic              btn_meta_q, btn_meta_d;
    logic              btn_sync_q, btn_sync_d;
    logic [DATA_W-1:0] chv_meta_q, chv_meta_d;
    logic [DATA_W-1:0] chv_sync_q, chv_sync_d;
    logic              deb_q, deb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic              espera_q, espera_d;
    logic              valido_q, valido_d;

    always_comb begin
        btn_meta_d = BotaoConfirma;
        btn_sync_d = btn_meta_q;
        chv_meta_d = Chaves;
        chv_sync_d = chv_meta_q;

        deb_d = deb_q;
        cnt_d = '0;
        if (btn_sync_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = btn_sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        state_d = state_q;
        dado_d  = dado_q;
        unique case (state_q)
            OCIOSO: begin
                if (In) state_d = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                // A rise landing on this edge keeps us here, so APERTO is always entered with the button released.
                if (!In)                 state_d = OCIOSO;
                else if (!deb_q && !deb_d) state_d = ESPERA_APERTO;
            end
            ESPERA_APERTO: begin
                if (!In) begin
                    state_d = OCIOSO;
                end else if (deb_q) begin
                    state_d = CONCLUIDO;
                    dado_d  = chv_sync_q;
                end
            end
            CONCLUIDO: begin
                state_d = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase

        espera_d = (state_d == ESPERA_SOLTAR) || (state_d == ESPERA_APERTO);
        valido_d = (state_d == CONCLUIDO);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= OCIOSO;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            chv_meta_q <= '0;
            chv_sync_q <= '0;
            deb_q      <= 1'b0;
            cnt_q      <= '0;
            dado_q     <= '0;
            espera_q   <= 1'b0;
            valido_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            chv_meta_q <= chv_meta_d;
            chv_sync_q <= chv_sync_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            dado_q     <= dado_d;
            espera_q   <= espera_d;
            valido_q   <= valido_d;
        end
    end

    // Stall must rise in the same cycle as In so the PC never passes an unconfirmed IN.
    assign Pausa            = ((state_q == OCIOSO) && In) ||
                              (state_q == ESPERA_SOLTAR) || (state_q == ESPERA_APERTO);
    assign DadoLido_Entrada = dado_q;
    assign EsperandoEntrada = espera_q;
    assign Valido           = valido_q;
endmodule
